// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, FSM state type and helpers for the BCD
//                arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Width of one packed BCD digit
  localparam int BCD_W    = 4;
  // Largest legal value of a BCD digit
  localparam int BCD_MAX  = 9;
  // Correction added to a binary digit sum that overflows past nine
  localparam int BCD_CORR = 6;

  // Sequencer states of the digit-serial adder
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when a 4-bit code is not a legal BCD digit (10..15)
  function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
    return (d > BCD_W'(BCD_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_add
//  Description : Combinational single-digit BCD adder with carry in/out and
//                an invalid-operand flag. Reusable by any BCD datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] s,
  output logic             cout,
  output logic             invalid
);

  // Binary sum of both digits plus carry; max 15+15+1 = 31 fits 5 bits
  logic [BCD_W:0]   w_bin;
  // Low nibble of the binary sum after adding the decimal correction
  logic [BCD_W-1:0] w_corr;
  // Binary sum exceeded the largest decimal digit
  logic             w_over;

  // Add, detect decimal overflow and apply the +6 correction modulo 16
  always_comb begin
    w_bin   = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    w_over  = (w_bin > (BCD_W+1)'(BCD_MAX));
    w_corr  = w_bin[BCD_W-1:0] + BCD_W'(BCD_CORR);
    s       = w_over ? w_corr : w_bin[BCD_W-1:0];
    cout    = w_over;
    invalid = digit_invalid(a) | digit_invalid(b);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder
//  Description : Digit-serial multi-digit BCD adder. Captures two packed BCD
//                operands and feeds one shared digit adder one digit per
//                clock, LSD first, rippling the decimal carry through a
//                register. Reports sum, carry out and a sticky invalid-digit
//                error with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    carry_out,
  output logic                    error
);

  // Digit index width; a single-digit adder still keeps a 1-bit index
  localparam int          IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(DIGITS - 1);

  // Sequencer state
  state_t                  r_state;
  state_t                  w_state_nxt;

  // Captured operands, so later changes on a/b have no effect
  logic [BCD_W*DIGITS-1:0] r_a;
  logic [BCD_W*DIGITS-1:0] r_b;
  // Current digit position and rippled decimal carry
  logic [IW-1:0]           r_idx;
  logic                    r_carry;
  // Result registers driving the outputs directly
  logic [BCD_W*DIGITS-1:0] r_sum;
  logic                    r_cout;
  logic                    r_error;
  logic                    r_busy;
  logic                    r_done;

  // Operands split into digit arrays for indexed selection
  logic [BCD_W-1:0]        w_a_dig [DIGITS];
  logic [BCD_W-1:0]        w_b_dig [DIGITS];

  // Shared digit adder connections
  logic [BCD_W-1:0]        w_dig_a;
  logic [BCD_W-1:0]        w_dig_b;
  logic [BCD_W-1:0]        w_dig_s;
  logic                    w_dig_cout;
  logic                    w_dig_invalid;
  logic                    w_last;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
    assign w_a_dig[gi] = r_a[gi*BCD_W +: BCD_W];
    assign w_b_dig[gi] = r_b[gi*BCD_W +: BCD_W];
  end

  assign w_dig_a = w_a_dig[r_idx];
  assign w_dig_b = w_b_dig[r_idx];
  assign w_last  = (r_idx == C_LAST);

  bcd_digit_add u_digit (
    .a       (w_dig_a),
    .b       (w_dig_b),
    .cin     (r_carry),
    .s       (w_dig_s),
    .cout    (w_dig_cout),
    .invalid (w_dig_invalid)
  );

  // State register plus registered busy/done decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_ADD);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_ADD;
      ST_ADD:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, digit sequencing and result accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        ST_ADD: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) r_sum[k*BCD_W +: BCD_W] <= w_dig_s;
          end
          r_carry <= w_dig_cout;
          if (w_dig_invalid) r_error <= 1'b1;
          if (w_last) begin
            r_cout <= w_dig_cout;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_adder
//  Description : Self-checking bench for bcd_serial_adder (DIGITS = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4*D-1:0] a = '0;
  logic [4*D-1:0] b = '0;
  logic          busy;
  logic          done;
  logic [4*D-1:0] sum;
  logic          carry_out;
  logic          error;

  int total = 0;
  int bad   = 0;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] esum;
    logic        ecout;
    logic        eerr;
    logic        chk_sum;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [15:0] v);
    for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Results captured in the done cycle by run_op
  logic [15:0] got_sum;
  logic        got_cout;
  logic        got_err;
  int          got_cyc;
  int          got_busy;
  logic        got_ok;

  // Issue one start and watch until done (bounded)
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_cyc = 0; got_busy = 0; got_ok = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clk);
      if (busy && done) chk("busy_and_done", 1, 0);
      if (busy) got_busy++;
      if (done) begin
        got_cyc  = n;
        got_sum  = sum;
        got_cout = carry_out;
        got_err  = error;
        got_ok   = 1'b1;
        break;
      end
    end
    if (!got_ok) chk("done_timeout", 0, 1);
  endtask

  task automatic run_and_check(input string name, input logic [15:0] va,
                               input logic [15:0] vb);
    int tot;
    logic bad_in;
    run_op(va, vb);
    bad_in = has_bad_digit(va) | has_bad_digit(vb);
    chk({name, "_err"}, got_err, bad_in);
    if (!bad_in) begin
      tot = bcd2int(va) + bcd2int(vb);
      chk({name, "_sum"}, got_sum, int2bcd(tot));
      chk({name, "_cout"}, got_cout, (tot >= 10000));
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h00A0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0042, 16'h0013, 16'h0055, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0905, 16'h0095, 16'h1000, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_err", error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].va, vecs[i].vb);
      chk($sformatf("vec%0d_err", i), got_err, vecs[i].eerr);
      if (vecs[i].chk_sum) begin
        chk($sformatf("vec%0d_sum", i), got_sum, vecs[i].esum);
        chk($sformatf("vec%0d_cout", i), got_cout, vecs[i].ecout);
      end
      if (i == 0) begin
        chk("latency", got_cyc, D + 1);
        chk("busy_cycles", got_busy, D);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("sum_holds", sum, 16'h6912);
      end
    end

    // Start while busy and during done are ignored; start right after done taken
    @(negedge clk);
    a = 16'h0123; b = 16'h0456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (done) begin got_ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("busy_start_done_seen", got_ok, 1);
    chk("busy_start_sum", sum, 16'h0579);
    a = 16'h2222; b = 16'h3333; start = 1'b1;
    @(negedge clk);
    chk("done_start_ignored", busy, 0);
    a = 16'h0008; b = 16'h0004;
    @(negedge clk);
    start = 1'b0;
    chk("after_done_accepted", busy, 1);
    got_ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (done) begin got_ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("after_done_seen", got_ok, 1);
    chk("after_done_sum", sum, 16'h0012);
    @(negedge clk);

    // Reset during the second ADD cycle aborts with no done
    @(negedge clk);
    a = 16'h4444; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", carry_out, 0);
    chk("abort_err", error, 0);
    rst_n = 1'b1;
    got_ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) got_ok = 1'b1;
    end
    chk("abort_no_done", got_ok, 0);
    run_and_check("post_abort", 16'h0005, 16'h0005);
    chk("post_abort_val", got_sum, 16'h0010);

    // Exhaustive digit-0 sweep
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        run_op(16'(x), 16'(y));
        chk($sformatf("sweep_%0d_%0d_sum", x, y), got_sum, int2bcd(x + y));
        chk($sformatf("sweep_%0d_%0d_cout", x, y), got_cout, 0);
      end
    end

    // Randomized operands against the decimal model
    for (int r = 0; r < 40; r++) begin
      logic [15:0] ra, rb;
      ra = int2bcd(int'($urandom_range(0, 9999)));
      rb = int2bcd(int'($urandom_range(0, 9999)));
      if ($urandom_range(0, 7) == 0) begin
        int p;
        p = int'($urandom_range(0, D - 1));
        ra[p*4 +: 4] = 4'(10 + $urandom_range(0, 5));
      end
      run_and_check($sformatf("rand%0d", r), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial multi-digit BCD adder controller. Accepts two packed BCD operands of `DIGITS` digits, then sequences a single-digit BCD adder stage one digit per clock, least-significant digit first, rippling the decimal carry through a register. It sits between the operand source (keypad/register logic) and the display path, and replaces a wide combinational BCD chain with one shared digit adder.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits per operand; minimum 1.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: request a new addition; sampled only in IDLE.
- `a`, input, 4*DIGITS: operand A, packed BCD, digit 0 in [3:0].
- `b`, input, 4*DIGITS: operand B, same packing.
- `busy`, output, 1: high while digits are being processed (ADD state).
- `done`, output, 1: one-cycle pulse; results are valid in this cycle.
- `sum`, output, 4*DIGITS: packed BCD result.
- `carry_out`, output, 1: decimal carry out of the top digit.
- `error`, output, 1: sticky for the operation; set if any operand digit > 9.

## Operation

- FSM states: IDLE, ADD, DONE.
- IDLE with `start`=1:
  - Capture `a` and `b` into internal registers.
  - Clear digit index, carry register, `sum` and `error`.
  - Go to ADD.
  - `start`=0 keeps the FSM in IDLE.
- ADD, each cycle, for digit index k:
  - Take digit k of A, digit k of B, and the carry register.
  - Binary sum s = a_k + b_k + c.
  - If s > 9: digit = (s + 6) mod 16 and carry = 1. Otherwise digit = s and carry = 0.
  - Write the digit into `sum[4k+3:4k]` and register the new carry.
  - If a_k > 9 or b_k > 9, set `error` (sticky). The digit and carry are still computed with the same rule; the `sum` value is then unspecified and must not be checked.
  - At k = DIGITS-1: load `carry_out` from the new carry and go to DONE. Otherwise increment k.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `start` is ignored in ADD and DONE; there is no queuing.
- `sum`, `carry_out` and `error` hold their values until the next accepted `start` clears them.
- Operands changing after capture have no effect.

## Timing

- Reset (`rst_n`=0 at a rising edge):
  - FSM goes to IDLE; digit index and carry register go to 0.
  - `busy`=0, `done`=0, `sum`=0, `carry_out`=0, `error`=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced.
- Start accepted at edge T0.
- `busy`=1 from T0 through edge T0+DIGITS (DIGITS cycles). Digit k is written at edge T0+k+1.
- `done`=1 in the cycle after edge T0+DIGITS. Latency from start to done is DIGITS+1 cycles; results are valid in the same cycle.
- `busy` and `done` are never high at the same time.
- Next start is accepted at earliest in the cycle after `done`. This gives a throughput of one addition per DIGITS+2 cycles.
- `busy`, `done` and `error` are registered outputs with no combinational paths from inputs.

## Structure

- Shared package `bcd_pkg`:
  - Constant `BCD_W` = 4.
  - Constant `BCD_MAX` = 9.
  - Constant `BCD_CORR` = 6.
  - FSM state typedef (IDLE/ADD/DONE).
- Sub-module `bcd_digit_add`: combinational one-digit adder.
  - Inputs: `a[3:0]`, `b[3:0]`, `cin`.
  - Outputs: `s[3:0]`, `cout`, `invalid`.
  - Instantiated once inside `bcd_serial_adder`. It is reusable by other BCD blocks.
- Digit index width is clog2(DIGITS), minimum 1 bit.

## Test plan

All scenarios use DIGITS=4, operands written as hex-packed BCD.
- Basic add: a=0x1234, b=0x5678, start one cycle.
  - `done` arrives 5 cycles later with `sum`=0x6912, `carry_out`=0, `error`=0.
  - `busy` high for exactly 4 cycles.
- Full ripple: a=0x9999, b=0x0001.
  - `sum`=0x0000, `carry_out`=1.
  - Then a=0x0000, b=0x0000 gives `sum`=0x0000, `carry_out`=0 (previous result cleared).
- Invalid digit: a=0x00A0, b=0x0000.
  - `done` with `error`=1. `sum` is not checked.
  - The next operation with valid operands reports `error`=0.
- Start while busy: pulse `start` with new operands during ADD and again in the DONE cycle.
  - Both are ignored; the result matches the first operands.
  - A `start` one cycle after `done` is accepted.
- Reset mid-operation: drive `rst_n`=0 on the 2nd ADD cycle.
  - All outputs are 0 on the next cycle and no `done` pulse appears.
  - A new start then completes normally: 0x0005 + 0x0005 gives `sum`=0x0010.
- Exhaustive digit check: sweep digit-0 pairs 0..9 × 0..9 with the upper digits at 0.
  - `sum` = decimal(a+b) on every pass.
  - `carry_out`=0 on every pass.
